// File: rtl/axi_master_read_if.sv
// axi_master_read_if: control, AXI read-channel and FIFO-write signals of the DMA read master.
interface axi_master_read_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
);
   logic              m_read_start;
   logic [ADDR_W-1:0] m_read_addr;
   logic [LEN_W-1:0]  m_read_len;
   logic              m_read_done;
   logic              m_read_busy;
   logic              m_read_err;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic              m_axi_arvalid;
   logic              m_axi_arready;
   logic [DATA_W-1:0] m_axi_rdata;
   logic [1:0]        m_axi_rresp;
   logic              m_axi_rvalid;
   logic              m_axi_rready;
   logic [DATA_W-1:0] fifo_wdata;
   logic              fifo_wen;
   logic              fifo_full;
   modport master (
      input  m_read_start, m_read_addr, m_read_len, m_axi_arready, m_axi_rdata,
             m_axi_rresp, m_axi_rvalid, fifo_full,
      output m_read_done, m_read_busy, m_read_err, m_axi_araddr, m_axi_arvalid,
             m_axi_rready, fifo_wdata, fifo_wen
   );
   modport slave (
      output m_read_start, m_read_addr, m_read_len, m_axi_arready, m_axi_rdata,
             m_axi_rresp, m_axi_rvalid, fifo_full,
      input  m_read_done, m_read_busy, m_read_err, m_axi_araddr, m_axi_arvalid,
             m_axi_rready, fifo_wdata, fifo_wen
   );
endinterface

// File: rtl/axi_master_read.sv
// axi_master_read: single-beat AXI reads of consecutive words pushed into the transfer FIFO.
// Define AXI_MASTER_READ_RESP_CHECK_EN to abort on a non-OKAY rresp and raise sticky m_read_err.
module axi_master_read #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 16,
   parameter int ADDR_INCR = 4
) (
   input logic clk,
   input logic rst,
   axi_master_read_if.master bus
);
   typedef enum logic [1:0] {IDLE, AR_PHASE, R_PHASE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [ADDR_W-1:0] next_addr;
   logic              accept;
   logic              resp_bad;
   assign bus.m_axi_rready = state == R_PHASE && !bus.fifo_full;
   assign accept = bus.m_axi_rvalid && bus.m_axi_rready;
   assign next_addr = addr + ADDR_W'(ADDR_INCR);
`ifdef AXI_MASTER_READ_RESP_CHECK_EN
   assign resp_bad = bus.m_axi_rresp != 2'b00;
`else
   assign resp_bad = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         addr              <= '0;
         remaining         <= '0;
         bus.m_axi_araddr  <= '0;
         bus.m_axi_arvalid <= 1'b0;
         bus.fifo_wdata    <= {DATA_W{1'b0}};
         bus.fifo_wen      <= 1'b0;
         bus.m_read_done   <= 1'b0;
         bus.m_read_busy   <= 1'b0;
         bus.m_read_err    <= 1'b0;
      end else begin
         bus.fifo_wen    <= 1'b0;
         bus.m_read_done <= 1'b0;
         case (state)
            IDLE: if (bus.m_read_start) begin
               addr           <= bus.m_read_addr;
               remaining      <= bus.m_read_len;
               bus.m_read_err <= 1'b0;
               if (bus.m_read_len == '0) begin
                  bus.m_read_done <= 1'b1;
               end else begin
                  bus.m_axi_arvalid <= 1'b1;
                  bus.m_axi_araddr  <= bus.m_read_addr;
                  bus.m_read_busy   <= 1'b1;
                  state             <= AR_PHASE;
               end
            end
            AR_PHASE: if (bus.m_axi_arready) begin
               bus.m_axi_arvalid <= 1'b0;
               state             <= R_PHASE;
            end
            R_PHASE: if (accept) begin
               // an error response is dropped rather than forwarded, and ends the block
               if (resp_bad) begin
                  bus.m_read_err  <= 1'b1;
                  bus.m_read_done <= 1'b1;
                  bus.m_read_busy <= 1'b0;
                  state           <= IDLE;
               end else begin
                  bus.fifo_wdata <= bus.m_axi_rdata;
                  bus.fifo_wen   <= 1'b1;
                  if (remaining == LEN_W'(1)) begin
                     bus.m_read_done <= 1'b1;
                     bus.m_read_busy <= 1'b0;
                     state           <= IDLE;
                  end else begin
                     addr              <= next_addr;
                     remaining         <= remaining - LEN_W'(1);
                     bus.m_axi_araddr  <= next_addr;
                     bus.m_axi_arvalid <= 1'b1;
                     state             <= AR_PHASE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_master_read.sv
// tb_axi_master_read: directed self-checking bench for axi_master_read.
module tb_axi_master_read;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   ar_hs = 0;
   int   wen_cnt = 0;
   int   done_cnt = 0;
   axi_master_read_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) bus ();
   axi_master_read #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .ADDR_INCR(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.m_axi_arvalid && bus.m_axi_arready) ar_hs++;
      if (bus.fifo_wen) wen_cnt++;
      if (bus.m_read_done) done_cnt++;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic start(input logic [31:0] a, input logic [15:0] n);
      bus.m_read_start = 1'b1;
      bus.m_read_addr  = a;
      bus.m_read_len   = n;
      tick();
      bus.m_read_start = 1'b0;
   endtask
   task automatic ar_phase(input logic [31:0] a, input int dly);
      repeat (dly) begin
         chk("ar_hold_valid", bus.m_axi_arvalid, 1);
         chk("ar_hold_addr", bus.m_axi_araddr, a);
         tick();
      end
      chk("arvalid", bus.m_axi_arvalid, 1);
      chk("araddr", bus.m_axi_araddr, a);
      bus.m_axi_arready = 1'b1;
      tick();
      bus.m_axi_arready = 1'b0;
      chk("arvalid_drop", bus.m_axi_arvalid, 0);
   endtask
   task automatic word(input logic [31:0] a, input int dly, input int full_cyc,
                       input logic [31:0] d, input logic last);
      ar_phase(a, dly);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = d;
      repeat (full_cyc) begin
         bus.fifo_full = 1'b1;
         #1;
         chk("rready_full", bus.m_axi_rready, 0);
         chk("wen_full", bus.fifo_wen, 0);
         tick();
      end
      bus.fifo_full = 1'b0;
      #1;
      chk("rready", bus.m_axi_rready, 1);
      tick();
      bus.m_axi_rvalid = 1'b0;
      chk("fifo_wen", bus.fifo_wen, 1);
      chk("fifo_wdata", bus.fifo_wdata, d);
      chk("done_with_wen", bus.m_read_done, last);
      chk("busy_after_beat", bus.m_read_busy, !last);
      tick();
      chk("wen_one_cycle", bus.fifo_wen, 0);
      chk("done_one_cycle", bus.m_read_done, 0);
   endtask
   task automatic chk_all_zero(input string tag);
      chk({tag, "_arvalid"}, bus.m_axi_arvalid, 0);
      chk({tag, "_araddr"}, bus.m_axi_araddr, 0);
      chk({tag, "_rready"}, bus.m_axi_rready, 0);
      chk({tag, "_wen"}, bus.fifo_wen, 0);
      chk({tag, "_wdata"}, bus.fifo_wdata, 0);
      chk({tag, "_done"}, bus.m_read_done, 0);
      chk({tag, "_busy"}, bus.m_read_busy, 0);
      chk({tag, "_err"}, bus.m_read_err, 0);
   endtask
   initial begin
      bus.m_read_start  = 1'b0;
      bus.m_read_addr   = '0;
      bus.m_read_len    = '0;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rdata   = '0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rvalid  = 1'b0;
      bus.fifo_full     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_all_zero("reset");
      // three-word block with a responsive slave
      start(32'h1000, 16'd3);
      chk("busy_start", bus.m_read_busy, 1);
      word(32'h1000, 0, 0, 32'hA1, 1'b0);
      word(32'h1004, 0, 0, 32'hA2, 1'b0);
      word(32'h1008, 0, 0, 32'hA3, 1'b1);
      chk("busy_end", bus.m_read_busy, 0);
      chk("t1_ar_count", ar_hs, 3);
      chk("t1_wen_count", wen_cnt, 3);
      chk("t1_done_count", done_cnt, 1);
      // zero-length request
      start(32'h2222, 16'd0);
      chk("len0_done", bus.m_read_done, 1);
      chk("len0_arvalid", bus.m_axi_arvalid, 0);
      chk("len0_busy", bus.m_read_busy, 0);
      tick();
      chk("len0_done_drop", bus.m_read_done, 0);
      chk("len0_ar_count", ar_hs, 3);
      // FIFO back-pressure on the first word
      start(32'h2000, 16'd2);
      word(32'h2000, 0, 5, 32'hC1, 1'b0);
      word(32'h2004, 0, 0, 32'hC2, 1'b1);
      chk("bp_wen_count", wen_cnt, 5);
      // slow arready; a start during the transfer must be ignored
      start(32'h3000, 16'd1);
      bus.m_read_start = 1'b1;
      bus.m_read_addr  = 32'h9999;
      bus.m_read_len   = 16'd0;
      ar_phase(32'h3000, 4);
      bus.m_read_start = 1'b0;
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'hD1;
      tick();
      bus.m_axi_rvalid = 1'b0;
      chk("slow_wdata", bus.fifo_wdata, 32'hD1);
      chk("slow_done", bus.m_read_done, 1);
      tick();
      chk("slow_ar_count", ar_hs, 6);
      chk("slow_done_count", done_cnt, 4);
      // address wrap
      start(32'hFFFF_FFFC, 16'd2);
      word(32'hFFFF_FFFC, 0, 0, 32'hE1, 1'b0);
      word(32'h0000_0000, 0, 0, 32'hE2, 1'b1);
      // reset while a beat is pending
      start(32'h4000, 16'd4);
      word(32'h4000, 0, 0, 32'hF1, 1'b0);
      ar_phase(32'h4004, 0);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'hF2;
      bus.fifo_full    = 1'b1;
      #1;
      chk("prerst_rready", bus.m_axi_rready, 0);
      rst = 1'b1;
      tick();
      chk_all_zero("midrst");
      rst = 1'b0;
      bus.m_axi_rvalid = 1'b0;
      bus.fifo_full    = 1'b0;
      tick();
      chk("postrst_arvalid", bus.m_axi_arvalid, 0);
      chk("postrst_busy", bus.m_read_busy, 0);
`ifdef AXI_MASTER_READ_RESP_CHECK_EN
      start(32'h5000, 16'd4);
      word(32'h5000, 0, 0, 32'hB1, 1'b0);
      ar_phase(32'h5004, 0);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'hBAD;
      bus.m_axi_rresp  = 2'b10;
      tick();
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rresp  = 2'b00;
      chk("err_wen", bus.fifo_wen, 0);
      chk("err_flag", bus.m_read_err, 1);
      chk("err_done", bus.m_read_done, 1);
      chk("err_busy", bus.m_read_busy, 0);
      chk("err_arvalid", bus.m_axi_arvalid, 0);
      tick();
      chk("err_sticky", bus.m_read_err, 1);
      chk("err_done_drop", bus.m_read_done, 0);
      start(32'h0, 16'd0);
      chk("err_clear", bus.m_read_err, 0);
      tick();
`else
      start(32'h5000, 16'd1);
      bus.m_axi_rresp = 2'b10;
      ar_phase(32'h5000, 0);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = 32'hBAD;
      tick();
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rresp  = 2'b00;
      chk("noerr_wen", bus.fifo_wen, 1);
      chk("noerr_wdata", bus.fifo_wdata, 32'hBAD);
      chk("noerr_flag", bus.m_read_err, 0);
      tick();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/axi_master_read.md
Name: axi_master_read

Overview:
- Source side of the DMA datapath; sits directly upstream of the write master.
- Reads a block of consecutive words from the AXI slave, one single-beat read per word (AR handshake, then R handshake).
- Pushes each returned word into the transfer FIFO, which the write master drains.
- Flow control: never accepts a beat while the FIFO is full. Pulses done after the last word is written into the FIFO.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 16, width of the word-count input
- ADDR_INCR, 4, byte increment between consecutive reads

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- m_read_start  input  1  start request; sampled only in IDLE
- m_read_addr  input  ADDR_W  first read address
- m_read_len  input  LEN_W  number of words to read
- m_read_done  output  1  one-cycle pulse at end of transfer
- m_read_busy  output  1  high whenever state is not IDLE
- m_read_err  output  1  sticky read-error flag (see Optional Feature)
- m_axi_araddr  output  ADDR_W  read address
- m_axi_arvalid  output  1  read address valid
- m_axi_arready  input  1  read address ready
- m_axi_rdata  input  DATA_W  read data
- m_axi_rresp  input  2  read response
- m_axi_rvalid  input  1  read data valid
- m_axi_rready  output  1  read data ready
- fifo_wdata  output  DATA_W  FIFO write data
- fifo_wen  output  1  FIFO write enable, one cycle per word
- fifo_full  input  1  FIFO full flag

Behaviour:
- Reset: on rst high at a clock edge, go to IDLE and clear all outputs to 0:
  - m_axi_araddr, m_axi_arvalid, m_axi_rready
  - fifo_wdata, fifo_wen
  - m_read_done, m_read_busy, m_read_err
  - internal address register and remaining-word counter
- Reset mid-transfer abandons any outstanding AXI transaction without further handshakes.
- States: IDLE, AR_PHASE, R_PHASE.
- IDLE:
  - m_read_done and fifo_wen are default 0 in every state unless set below.
  - On m_read_start, latch m_read_addr into the address register and m_read_len into the remaining counter.
  - If m_read_len == 0: m_read_done = 1 next cycle; stay in IDLE; no AXI activity.
  - Otherwise: m_axi_arvalid = 1 and m_axi_araddr = latched address next cycle; go to AR_PHASE.
  - Start is ignored outside IDLE.
- AR_PHASE:
  - Hold m_axi_arvalid and m_axi_araddr stable until m_axi_arready.
  - On arready: m_axi_arvalid = 0 next cycle; go to R_PHASE.
- R_PHASE:
  - m_axi_rready is combinational: (state == R_PHASE) and not fifo_full.
  - A beat is accepted when m_axi_rvalid and m_axi_rready are both high.
  - On acceptance, next cycle: fifo_wdata = m_axi_rdata and fifo_wen = 1 for exactly one cycle.
  - If remaining == 1: m_read_done = 1 in the same cycle as that last fifo_wen; go to IDLE.
  - Else: address += ADDR_INCR (wraps modulo 2^ADDR_W), remaining -= 1, m_axi_arvalid = 1 with the new address, go to AR_PHASE.
- Latency:
  - start → arvalid: 1 cycle.
  - arready → rready possible: next cycle.
  - beat → fifo_wen: 1 cycle.
- FIFO full while rvalid is high: rready stays low and the beat waits. The slave holds rdata; no beat is lost.
- fifo_full is sampled at acceptance. This block is the only FIFO writer and at most one word is in flight, so the FIFO always has space for the registered write.
- m_read_busy = 1 from the cycle after an accepted nonzero-length start through the cycle the FSM returns to IDLE.
- m_read_len changes during a transfer have no effect.

Optional Feature:
- Macro: AXI_MASTER_READ_RESP_CHECK_EN
- Defined:
  - An accepted beat with m_axi_rresp != 2'b00 is not written to the FIFO (fifo_wen stays 0).
  - m_read_err is set, the transfer terminates, m_read_done pulses next cycle, and the FSM returns to IDLE.
  - m_read_err stays high until the next accepted m_read_start or rst.
- Undefined: m_axi_rresp is ignored, every accepted beat is written, and m_read_err is tied 0.

Test Plan:
- rst, then start with addr=0x1000, len=3, slave arready/rvalid immediate, data A1,A2,A3 → araddr sequence 0x1000, 0x1004, 0x1008; three fifo_wen pulses with A1,A2,A3; m_read_done pulses together with the third fifo_wen; busy low afterwards.
- start with len=0 → m_read_done high exactly one cycle later; arvalid never asserts; busy stays 0.
- len=2, fifo_full held high 5 cycles while rvalid=1 → rready low those 5 cycles; beat accepted the cycle after full drops; no duplicate or lost word.
- arready delayed 4 cycles → arvalid and araddr held stable for all 4 cycles; exactly one AR handshake per word.
- addr=0xFFFFFFFC, len=2 → second araddr is 0x00000000 (wrap).
- rst asserted during R_PHASE of a len=4 transfer → next cycle all outputs 0 and state IDLE. With AXI_MASTER_READ_RESP_CHECK_EN: rresp=2'b10 on word 2 of len=4 → only word 1 written, m_read_err=1, done pulses once.
